// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> hazard scoreboard bundle: source/destination description of the
// instruction in ID plus the bypass, stall and flag-forwarding answers.
interface hazard_scoreboard_if #(
  parameter int ADDR_W    = 5,
  parameter int NUM_READS = 2,
  parameter int DEPTH     = 3
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic [NUM_READS*ADDR_W-1:0] rs_addr;
  logic [NUM_READS-1:0]        rs_valid;
  logic [ADDR_W-1:0]           rd_addr;
  logic                        rd_we;
  logic                        is_load;
  logic                        flag_wr;
  logic                        flag_rd;
  logic                        id_valid;
  logic                        flush;
  logic                        freeze;
  logic [NUM_READS*SEL_W-1:0]  fwd_sel;
  logic                        stall;
  logic                        flag_fwd;
  logic [31:0]                 stall_cnt;

  modport master (
    output rs_addr, rs_valid, rd_addr, rd_we, is_load, flag_wr, flag_rd,
           id_valid, flush, freeze,
    input  fwd_sel, stall, flag_fwd, stall_cnt
  );

  modport slave (
    input  rs_addr, rs_valid, rd_addr, rd_we, is_load, flag_wr, flag_rd,
           id_valid, flush, freeze,
    output fwd_sel, stall, flag_fwd, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard: a DEPTH-entry record of instructions past ID
// that yields per-port bypass selects, load-use stall and flag bypass.
module hazard_scoreboard #(
  parameter int ADDR_W     = 5,
  parameter int NUM_READS  = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int ZERO_REG   = 31,
  parameter int RF_BYPASS  = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard_scoreboard_if.slave  bus
);
  localparam int SEL_W   = $clog2(DEPTH + 1);
  localparam int E_W     = ADDR_W + 4;
  localparam int FWD_MAX = (RF_BYPASS != 0) ? DEPTH - 1 : DEPTH;

  // Entry layout: {v, we, addr, ld, fw}
  logic [E_W-1:0]             ent_reg [1:DEPTH];
  logic [DEPTH:1]             ent_v;
  logic [DEPTH:1]             ent_we;
  logic [DEPTH:1]             ent_ld;
  logic [DEPTH:1]             ent_fw;
  logic [ADDR_W-1:0]          ent_addr [1:DEPTH];
  logic [DEPTH:1]             hazard;

  logic [NUM_READS*SEL_W-1:0] sel_next;
  logic [NUM_READS-1:0]       ld_hit;
  logic [ADDR_W-1:0]          rs_cur;
  int                         best;
  logic                       best_ld;
  logic                       stall_next;
  logic                       capture;
  logic [31:0]                cnt_reg;

  genvar gi;
  generate
    for (gi = 1; gi <= DEPTH; gi++) begin : g_entry
      assign ent_v[gi]    = ent_reg[gi][E_W-1];
      assign ent_we[gi]   = ent_reg[gi][E_W-2];
      assign ent_addr[gi] = ent_reg[gi][ADDR_W+1:2];
      assign ent_ld[gi]   = ent_reg[gi][1];
      assign ent_fw[gi]   = ent_reg[gi][0];
      assign hazard[gi]   = ent_v[gi] & ent_we[gi] &
                            (ent_addr[gi] != ADDR_W'(ZERO_REG));
    end
  endgenerate

  // Scan oldest-to-youngest so the youngest matching stage is left in best;
  // only that youngest producer decides whether a load-use stall is needed.
  always_comb begin
    sel_next = '0;
    ld_hit   = '0;
    rs_cur   = '0;
    best     = 0;
    best_ld  = 1'b0;
    for (int p = 0; p < NUM_READS; p++) begin
      rs_cur  = bus.rs_addr[p*ADDR_W +: ADDR_W];
      best    = 0;
      best_ld = 1'b0;
      if (bus.rs_valid[p] && (rs_cur != ADDR_W'(ZERO_REG))) begin
        for (int k = FWD_MAX; k >= 1; k--) begin
          if (hazard[k] && (ent_addr[k] == rs_cur)) begin
            best    = k;
            best_ld = ent_ld[k];
          end
        end
      end
      sel_next[p*SEL_W +: SEL_W] = SEL_W'(best);
      ld_hit[p] = best_ld && (best != 0) && (best < LOAD_STAGE);
    end
  end

  assign stall_next    = bus.id_valid & ~bus.flush & (|ld_hit);
  assign capture       = ~(stall_next | bus.flush);

  assign bus.fwd_sel   = sel_next;
  assign bus.stall     = stall_next;
  assign bus.flag_fwd  = bus.flag_rd & ent_v[1] & ent_fw[1];
  assign bus.stall_cnt = cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        ent_reg[k] <= '0;
      end
      cnt_reg <= '0;
    end else if (!bus.freeze) begin
      for (int k = DEPTH; k >= 2; k--) begin
        ent_reg[k] <= ent_reg[k-1];
      end
      // A stalled or flushed ID slot enters EX as an all-zero bubble.
      ent_reg[1] <= capture ? {bus.id_valid, bus.rd_we, bus.rd_addr, bus.is_load, bus.flag_wr}
                            : '0;
      if (stall_next && (cnt_reg != 32'hFFFF_FFFF)) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: default build (a) and DEPTH=5/LOAD_STAGE=3/NUM_READS=3 build (b).
module tb_hazard_scoreboard;
  logic clk;
  logic rst_n_a;
  logic rst_n_b;
  int   checks;
  int   errors;
  int   txn;

  hazard_scoreboard_if #(.ADDR_W(5), .NUM_READS(2), .DEPTH(3)) bus_a ();
  hazard_scoreboard_if #(.ADDR_W(5), .NUM_READS(3), .DEPTH(5)) bus_b ();

  hazard_scoreboard #(
    .ADDR_W(5), .NUM_READS(2), .DEPTH(3), .LOAD_STAGE(2), .ZERO_REG(31), .RF_BYPASS(1)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (bus_a.slave)
  );

  hazard_scoreboard #(
    .ADDR_W(5), .NUM_READS(3), .DEPTH(5), .LOAD_STAGE(3), .ZERO_REG(31), .RF_BYPASS(1)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    txn++;
    $display("txn %0d t=%0t a:sel=%0h stall=%0b flag=%0b cnt=%0d b:sel=%0h stall=%0b cnt=%0d",
             txn, $time, bus_a.fwd_sel, bus_a.stall, bus_a.flag_fwd, bus_a.stall_cnt,
             bus_b.fwd_sel, bus_b.stall, bus_b.stall_cnt);
    @(negedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [4:0] r0, input logic v0, input logic [4:0] r1,
                         input logic v1, input logic [4:0] rd, input logic we,
                         input logic ld, input logic fw, input logic fr);
    bus_a.rs_addr  = {r1, r0};
    bus_a.rs_valid = {v1, v0};
    bus_a.rd_addr  = rd;
    bus_a.rd_we    = we;
    bus_a.is_load  = ld;
    bus_a.flag_wr  = fw;
    bus_a.flag_rd  = fr;
    bus_a.id_valid = 1'b1;
    bus_a.flush    = 1'b0;
    bus_a.freeze   = 1'b0;
    #1;
  endtask

  task automatic drive_b(input logic [4:0] r0, input logic v0, input logic [4:0] r1,
                         input logic v1, input logic [4:0] r2, input logic v2,
                         input logic [4:0] rd, input logic we, input logic ld);
    bus_b.rs_addr  = {r2, r1, r0};
    bus_b.rs_valid = {v2, v1, v0};
    bus_b.rd_addr  = rd;
    bus_b.rd_we    = we;
    bus_b.is_load  = ld;
    bus_b.flag_wr  = 1'b0;
    bus_b.flag_rd  = 1'b0;
    bus_b.id_valid = 1'b1;
    bus_b.flush    = 1'b0;
    bus_b.freeze   = 1'b0;
    #1;
  endtask

  task automatic idle_b();
    bus_b.rs_addr  = '0;
    bus_b.rs_valid = '0;
    bus_b.rd_addr  = '0;
    bus_b.rd_we    = 1'b0;
    bus_b.is_load  = 1'b0;
    bus_b.flag_wr  = 1'b0;
    bus_b.flag_rd  = 1'b0;
    bus_b.id_valid = 1'b0;
    bus_b.flush    = 1'b0;
    bus_b.freeze   = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    txn     = 0;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    bus_a.rs_addr  = '0;
    bus_a.rs_valid = '0;
    bus_a.rd_addr  = '0;
    bus_a.rd_we    = 1'b0;
    bus_a.is_load  = 1'b0;
    bus_a.flag_wr  = 1'b0;
    bus_a.flag_rd  = 1'b0;
    bus_a.id_valid = 1'b0;
    bus_a.flush    = 1'b0;
    bus_a.freeze   = 1'b0;
    idle_b();

    @(negedge clk);
    #1;
    chk("a_rst_sel",   32'(bus_a.fwd_sel),   32'd0);
    chk("a_rst_stall", 32'(bus_a.stall),     32'd0);
    chk("a_rst_flag",  32'(bus_a.flag_fwd),  32'd0);
    chk("a_rst_cnt",   bus_a.stall_cnt,      32'd0);
    rst_n_a = 1'b1;

    // Forwarding distance: stage 1, stage 2, then regfile once in WB
    drive_a(5, 1, 6, 1, 1, 1, 0, 0, 0);
    chk("a_add_x1_sel", 32'(bus_a.fwd_sel), 32'd0);
    step();
    drive_a(1, 1, 8, 1, 7, 1, 0, 0, 0);
    chk("a_fwd1_sel",   32'(bus_a.fwd_sel), 32'd1);
    chk("a_fwd1_stall", 32'(bus_a.stall),   32'd0);
    step();
    drive_a(7, 1, 1, 1, 9, 1, 0, 0, 0);
    chk("a_fwd2_sel",   32'(bus_a.fwd_sel), 32'd9);
    step();
    drive_a(1, 1, 7, 1, 10, 1, 0, 0, 0);
    chk("a_wb_sel",     32'(bus_a.fwd_sel), 32'd8);
    step();

    // Load-use interlock
    drive_a(3, 1, 0, 0, 2, 1, 1, 0, 0);
    chk("a_ld_sel",     32'(bus_a.fwd_sel), 32'd0);
    step();
    drive_a(2, 1, 9, 1, 11, 1, 0, 0, 0);
    chk("a_lu_stall",   32'(bus_a.stall),     32'd1);
    chk("a_lu_sel",     32'(bus_a.fwd_sel),   32'd1);
    chk("a_lu_cnt0",    bus_a.stall_cnt,      32'd0);
    step();
    chk("a_lu2_stall",  32'(bus_a.stall),     32'd0);
    chk("a_lu2_sel",    32'(bus_a.fwd_sel),   32'd2);
    chk("a_lu2_cnt",    bus_a.stall_cnt,      32'd1);
    step();

    // Zero register never forwards or stalls
    drive_a(0, 0, 0, 0, 31, 1, 0, 0, 0);
    step();
    drive_a(31, 1, 11, 1, 31, 1, 1, 0, 0);
    chk("a_z1_sel",     32'(bus_a.fwd_sel), 32'd8);
    chk("a_z1_stall",   32'(bus_a.stall),   32'd0);
    step();
    drive_a(31, 1, 31, 1, 13, 1, 0, 0, 0);
    chk("a_z2_sel",     32'(bus_a.fwd_sel), 32'd0);
    chk("a_z2_stall",   32'(bus_a.stall),   32'd0);
    step();

    // Flag bypass
    drive_a(0, 0, 0, 0, 12, 1, 0, 1, 0);
    chk("a_adds_flag",  32'(bus_a.flag_fwd), 32'd0);
    step();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("a_blt_flag",   32'(bus_a.flag_fwd), 32'd1);
    step();
    drive_a(0, 0, 0, 0, 12, 1, 0, 1, 0);
    step();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("a_nop_flag",   32'(bus_a.flag_fwd), 32'd0);
    step();

    // Flush beats stall and leaves a bubble in EX
    drive_a(0, 0, 0, 0, 3, 1, 1, 0, 0);
    step();
    drive_a(3, 1, 0, 0, 14, 1, 0, 1, 0);
    bus_a.flush = 1'b1;
    #1;
    chk("a_fl_stall",   32'(bus_a.stall),   32'd0);
    chk("a_fl_sel",     32'(bus_a.fwd_sel), 32'd1);
    step();
    drive_a(3, 1, 14, 1, 15, 1, 0, 0, 1);
    chk("a_bub_sel",    32'(bus_a.fwd_sel),  32'd2);
    chk("a_bub_flag",   32'(bus_a.flag_fwd), 32'd0);
    chk("a_bub_cnt",    bus_a.stall_cnt,     32'd1);
    step();

    // Freeze holds entries and the counter during a stall
    drive_a(0, 0, 0, 0, 4, 1, 1, 0, 0);
    step();
    drive_a(4, 1, 0, 0, 16, 1, 0, 0, 0);
    bus_a.freeze = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("a_frz_stall", 32'(bus_a.stall),   32'd1);
      chk("a_frz_sel",   32'(bus_a.fwd_sel), 32'd1);
      chk("a_frz_cnt",   bus_a.stall_cnt,    32'd1);
      step();
    end
    bus_a.freeze = 1'b0;
    #1;
    chk("a_thaw_stall", 32'(bus_a.stall), 32'd1);
    chk("a_thaw_cnt",   bus_a.stall_cnt,  32'd1);
    step();
    chk("a_post_stall", 32'(bus_a.stall),   32'd0);
    chk("a_post_sel",   32'(bus_a.fwd_sel), 32'd2);
    chk("a_post_cnt",   bus_a.stall_cnt,    32'd2);

    // Deep build: two-cycle load-use, then reset mid-stall
    rst_n_b = 1'b1;
    drive_b(0, 0, 0, 0, 0, 0, 4, 1, 1);
    chk("b_ld_sel",     32'(bus_b.fwd_sel), 32'd0);
    step();
    drive_b(20, 1, 0, 0, 4, 1, 21, 1, 0);
    chk("b_s1_stall",   32'(bus_b.stall),   32'd1);
    chk("b_s1_sel",     32'(bus_b.fwd_sel), 32'd64);
    step();
    chk("b_s2_stall",   32'(bus_b.stall),   32'd1);
    chk("b_s2_sel",     32'(bus_b.fwd_sel), 32'd128);
    chk("b_s2_cnt",     bus_b.stall_cnt,    32'd1);
    step();
    chk("b_s3_stall",   32'(bus_b.stall),   32'd0);
    chk("b_s3_sel",     32'(bus_b.fwd_sel), 32'd192);
    chk("b_s3_cnt",     bus_b.stall_cnt,    32'd2);
    step();
    drive_b(0, 0, 0, 0, 0, 0, 5, 1, 1);
    step();
    drive_b(5, 1, 0, 0, 0, 0, 22, 1, 0);
    chk("b_t1_stall",   32'(bus_b.stall),   32'd1);
    chk("b_t1_cnt",     bus_b.stall_cnt,    32'd2);
    step();
    chk("b_t2_stall",   32'(bus_b.stall),   32'd1);
    chk("b_t2_sel",     32'(bus_b.fwd_sel), 32'd2);
    chk("b_t2_cnt",     bus_b.stall_cnt,    32'd3);
    rst_n_b = 1'b0;
    #1;
    chk("b_rst_sel",    32'(bus_b.fwd_sel),  32'd0);
    chk("b_rst_stall",  32'(bus_b.stall),    32'd0);
    chk("b_rst_flag",   32'(bus_b.flag_fwd), 32'd0);
    chk("b_rst_cnt",    bus_b.stall_cnt,     32'd0);
    idle_b();
    step();
    rst_n_b = 1'b1;

    // Non-load at stage 1 shadows a load at stage 2: forward, no stall
    drive_b(0, 0, 0, 0, 0, 0, 6, 1, 1);
    step();
    drive_b(0, 0, 0, 0, 0, 0, 6, 1, 0);
    chk("b_sh0_stall",  32'(bus_b.stall), 32'd0);
    step();
    drive_b(6, 1, 0, 0, 0, 0, 23, 1, 0);
    chk("b_sh_sel",     32'(bus_b.fwd_sel), 32'd1);
    chk("b_sh_stall",   32'(bus_b.stall),   32'd0);
    chk("b_sh_cnt",     bus_b.stall_cnt,    32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding scoreboard for the in-order pipelined core, generalising the fixed two-port, EX/MEM-only forwarding unit. It sits beside the ID stage and records every instruction issued past ID in a DEPTH-entry shift register (EX, MEM, WB, …). From that record it drives a bypass select per read port, a load-use stall, a flag bypass and a saturating stall counter. It has configurable depth, read-port count, load-result stage and zero register, and it handles real load-use interlocks and flush bubbles, which the current unit does not.

## Interface
- ADDR_W, 5, register address width
- NUM_READS, 2, number of ID read ports
- DEPTH, 3, tracked stages after ID (stage 1 = EX … stage DEPTH = WB)
- LOAD_STAGE, 2, first stage whose output carries load data (2 = MEM output)
- ZERO_REG, 31, hard-zero register address; never a hazard
- RF_BYPASS, 1, 1 = regfile writes before it reads, so stage DEPTH is never forwarded
- SEL_W, $clog2(DEPTH+1), derived width of each select
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- rs_addr  in  NUM_READS*ADDR_W  ID source addresses; port p is bits [p*ADDR_W +: ADDR_W]
- rs_valid  in  NUM_READS  port p actually reads its register
- rd_addr  in  ADDR_W  ID destination address
- rd_we  in  1  ID instruction writes rd_addr
- is_load  in  1  ID instruction is a load
- flag_wr  in  1  ID instruction sets flags
- flag_rd  in  1  ID instruction consumes flags (conditional branch)
- id_valid  in  1  ID holds a real instruction
- flush  in  1  kill the ID instruction this cycle
- freeze  in  1  global hold (e.g. memory wait); no state change
- fwd_sel  out  NUM_READS*SEL_W  per port: 0 = regfile, k = result of stage k
- stall  out  1  hold PC and IF/ID; ID_EX loads a bubble
- flag_fwd  out  1  1 = take flags from the live ALU, 0 = take them from the flag register
- stall_cnt  out  32  saturating count of stall cycles

## Operation
- Each entry holds {v, we, addr, ld, fw}. Entry k describes the instruction currently in stage k.
- An entry is a write hazard when v & we & addr != ZERO_REG.
- Forwarding for port p with rs_valid[p]=1:
  - Candidates are write-hazard entries with addr == rs_addr[p].
  - Stage DEPTH is excluded when RF_BYPASS=1.
  - fwd_sel takes the smallest matching k (youngest wins); with no match, fwd_sel = 0.
  - rs_valid[p]=0 or rs_addr[p]==ZERO_REG gives fwd_sel = 0.
- Load-use stall: stall = id_valid & !flush & any port p that matches a write-hazard entry k with ld=1 and k < LOAD_STAGE.
  - When stall=1, fwd_sel is don't-care, but it must still be computed as above.
- flag_fwd = flag_rd & entry1.v & entry1.fw. Entries beyond stage 1 have already committed flags, so flags never cause a stall.
- Shift on each clock edge when freeze=0:
  - entry k+1 ← entry k for k = 1..DEPTH-1; the old entry DEPTH is dropped.
  - entry 1 ← {id_valid,rd_we,rd_addr,is_load,flag_wr} when not (stall or flush); otherwise entry 1 ← bubble (all zero).
- With freeze=1, all entries and stall_cnt hold. Outputs still follow the inputs combinationally.
- stall_cnt increments on each edge with stall=1 & freeze=0 and saturates at 32'hFFFF_FFFF.
- Simultaneous events:
  - flush wins over stall: stall=0 and a bubble is inserted.
  - freeze wins over everything.
  - A source matching the same register at several stages forwards from the youngest.
  - A non-load at stage 1 and a load at stage 2 to the same register: forward stage 1, no stall.

## Timing
- fwd_sel, stall and flag_fwd are combinational from the ID inputs and the registered entries, valid in the same cycle.
- State updates on the rising edge of clk.
- A load-use stall lasts exactly LOAD_STAGE-1 cycles (1 at the default), after which the load sits at stage LOAD_STAGE and fwd_sel = LOAD_STAGE.
- Asserting reset (low) at any time, including mid-stall, immediately clears all entries and stall_cnt. Outputs are then fwd_sel = 0, stall = 0, flag_fwd = 0 and stall_cnt = 0.
- The first edge after reset is released captures normally.
- Every output is fully defined at every cycle and never X after reset.

## Test plan
- ADD X1 issued, then next cycle SUB reading X1 on port 0 → fwd_sel[0]=1, stall=0. One cycle later a reader of X1 → fwd_sel=2. One more cycle → fwd_sel=0 (RF_BYPASS=1).
- LDUR X2 then ADD reading X2 → stall=1 for one cycle, bubble enters EX, stall_cnt=1. Next cycle fwd_sel=2, stall=0.
- Writes to X31 followed by a reader of X31, including a load to X31 → fwd_sel=0, stall=0.
- ADDS then B.LT with flag_rd=1 → flag_fwd=1. With a NOP between them → flag_fwd=0.
- LDUR X3 followed by a reader of X3 with flush=1 → stall=0 and entry 1 is a bubble. Asserting freeze=1 during a stall holds the entries and stall_cnt for 3 cycles.
- DEPTH=5, LOAD_STAGE=3, NUM_READS=3 build: LDUR X4 then a reader of X4 → 2 stall cycles, then fwd_sel=3. Asserting reset during the second stall cycle clears all outputs immediately.
